// File: rtl/bin_to_rns_9_8_7_seq_pkg.sv
// Shared constants and types for the (7, 8, 9) residue number system blocks.
// Moduli, residue widths, dynamic range and the converter state encoding.
package rns_9_8_7_pkg;

    localparam int M1 = 7;
    localparam int M2 = 8;
    localparam int M3 = 9;
    localparam int RANGE = 504;

    localparam int W1 = 3;
    localparam int W2 = 3;
    localparam int W3 = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to hold a bit counter that loads with w and counts down to 0.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bin_to_rns_9_8_7_seq_if.sv
// Valid/ready input side and residue output side of the binary-to-RNS converter.
// slave is the converter's view, master is the producer/consumer view.
interface bin_to_rns_9_8_7_seq_if #(
    parameter int IN_W = 9
);
    import rns_9_8_7_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic                out_valid;
    logic                out_ready;
    logic [W1-1:0]       x1;
    logic [W2-1:0]       x2;
    logic [W3-1:0]       x3;
    logic                ovf;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, x1, x2, x3, ovf
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, x1, x2, x3, ovf
    );

endinterface

// File: rtl/bin_to_rns_9_8_7_seq_mod_step.sv
// One Horner step of a residue: (2*r + b) mod M, combinational.
// Power-of-two modulus 8 degenerates into a plain shift-in.
module rns_mod_step #(
    parameter int M = 7,
    parameter int W = 3
) (
    input  logic [W-1:0] r_i,
    input  logic         b_i,
    output logic [W-1:0] r_o
);

    localparam logic [4:0] M_C = 5'(M);

    generate
        if (M == 8) begin : g_shift
            assign r_o = {r_i[W-2:0], b_i};
        end else begin : g_sub
            logic [4:0] sum_s;
            logic [4:0] sub1_s;
            logic [4:0] sub2_s;

            // 2*r + b is at most 2*(M-1)+1, so two conditional subtracts always suffice.
            always_comb begin
                sum_s  = 5'({r_i, b_i});
                sub1_s = (sum_s >= M_C) ? (sum_s - M_C) : sum_s;
                sub2_s = (sub1_s >= M_C) ? (sub1_s - M_C) : sub1_s;
                r_o    = W'(sub2_s);
            end
        end
    endgenerate

endmodule

// File: rtl/bin_to_rns_9_8_7_seq.sv
// Bit-serial MSB-first binary to RNS (7, 8, 9) converter with valid/ready on both sides.
// Residues are the state registers themselves, so they hold between conversions.
module bin_to_rns_9_8_7_seq
    import rns_9_8_7_pkg::*;
#(
    parameter int IN_W = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    bin_to_rns_9_8_7_seq_if.slave        bus
);

    localparam int CNT_W = cnt_width(IN_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IN_W-1:0]   sh_q, sh_d;
    logic [W1-1:0]     r7_q, r7_d, r7_step_s;
    logic [W2-1:0]     r8_q, r8_d, r8_step_s;
    logic [W3-1:0]     r9_q, r9_d, r9_step_s;
    logic              ovf_q, ovf_d;
    logic              ovf_cmp_s;
    logic              bit_s;

    assign bit_s = sh_q[IN_W-1];

    // Widths below 9 bits can never reach 504.
    generate
        if (IN_W >= 9) begin : g_ovf
            assign ovf_cmp_s = (bus.in_data >= IN_W'(RANGE));
        end else begin : g_no_ovf
            assign ovf_cmp_s = 1'b0;
        end
    endgenerate

    rns_mod_step #(.M(M1), .W(W1)) u_step7 (.r_i(r7_q), .b_i(bit_s), .r_o(r7_step_s));
    rns_mod_step #(.M(M2), .W(W2)) u_step8 (.r_i(r8_q), .b_i(bit_s), .r_o(r8_step_s));
    rns_mod_step #(.M(M3), .W(W3)) u_step9 (.r_i(r9_q), .b_i(bit_s), .r_o(r9_step_s));

    // State, counter, shift register and residue registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            sh_q    <= {IN_W{1'b0}};
            r7_q    <= {W1{1'b0}};
            r8_q    <= {W2{1'b0}};
            r9_q    <= {W3{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            r7_q    <= r7_d;
            r8_q    <= r8_d;
            r9_q    <= r9_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath updates for accept, bit steps and output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        r7_d    = r7_q;
        r8_d    = r8_q;
        r9_d    = r9_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    sh_d    = bus.in_data;
                    r7_d    = {W1{1'b0}};
                    r8_d    = {W2{1'b0}};
                    r9_d    = {W3{1'b0}};
                    ovf_d   = ovf_cmp_s;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                sh_d  = {sh_q[IN_W-2:0], 1'b0};
                r7_d  = r7_step_s;
                r8_d  = r8_step_s;
                r9_d  = r9_step_s;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.x1        = r7_q;
    assign bus.x2        = r8_q;
    assign bus.x3        = r9_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_rns_9_8_7_seq.sv
// Self-checking bench for the binary to RNS (7, 8, 9) converter.
// Directed table, handshake corner sequences and a randomized sweep against plain modulo arithmetic.
module tb_bin_to_rns_9_8_7_seq;
    import rns_9_8_7_pkg::*;

    localparam int IN_W = 9;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    bin_to_rns_9_8_7_seq_if #(.IN_W(IN_W)) bus ();

    bin_to_rns_9_8_7_seq #(.IN_W(IN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int v;
        int e1;
        int e2;
        int e3;
        int eo;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_wait", bus.in_ready, 1);
    endtask

    task automatic accept(input int v);
        wait_idle();
        bus.in_data  = IN_W'(v);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = IN_W'($urandom);
        chk("in_ready_after_accept", bus.in_ready, 0);
    endtask

    task automatic wait_done();
        int n;
        int bad;
        n = 0;
        bad = 0;
        while (!bus.out_valid && n < 50) begin
            if (bus.in_ready) bad = 1;
            step();
            n++;
        end
        chk("latency", n, IN_W);
        chk("in_ready_busy", bad, 0);
    endtask

    task automatic check_res(input string tag, input int e1, input int e2, input int e3, input int eo);
        chk({tag, ".x1"}, bus.x1, e1);
        chk({tag, ".x2"}, bus.x2, e2);
        chk({tag, ".x3"}, bus.x3, e3);
        chk({tag, ".ovf"}, bus.ovf, eo);
    endtask

    task automatic check_model(input string tag, input int v);
        check_res(tag, v % 7, v % 8, v % 9, (v >= 504) ? 1 : 0);
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("in_ready_after_release", bus.in_ready, 1);
        chk("out_valid_after_release", bus.out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{10, 3, 2, 1, 0};
        tbl[1] = '{0, 0, 0, 0, 0};
        tbl[2] = '{503, 6, 7, 8, 0};
        tbl[3] = '{504, 0, 0, 0, 1};
        tbl[4] = '{511, 0, 7, 7, 1};
        tbl[5] = '{100, 2, 4, 1, 0};
        tbl[6] = '{255, 3, 7, 3, 0};
        tbl[7] = '{1, 1, 1, 1, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("reset.in_ready", bus.in_ready, 1);
        chk("reset.out_valid", bus.out_valid, 0);
        check_res("reset", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            accept(tbl[i].v);
            wait_done();
            check_res($sformatf("vec%0d", tbl[i].v), tbl[i].e1, tbl[i].e2, tbl[i].e3, tbl[i].eo);
            release_out();
        end

        // Output held in DONE with out_ready low; in_valid asserted must be ignored.
        accept(100);
        wait_done();
        bus.in_valid = 1'b1;
        bus.in_data  = IN_W'(7);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold.out_valid", bus.out_valid, 1);
            chk("hold.in_ready", bus.in_ready, 0);
            check_res("hold", 2, 4, 1, 0);
        end
        release_out();
        bus.in_valid = 1'b0;
        check_res("after_release", 2, 4, 1, 0);
        step();
        chk("no_merge.in_ready", bus.in_ready, 1);
        check_res("no_merge", 2, 4, 1, 0);

        // Asynchronous reset mid-BUSY.
        accept(255);
        repeat (4) step();
        rst = 1'b1;
        #1;
        chk("rst_busy.in_ready", bus.in_ready, 1);
        chk("rst_busy.out_valid", bus.out_valid, 0);
        check_res("rst_busy", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        accept(255);
        wait_done();
        check_res("post_rst255", 3, 7, 3, 0);
        release_out();

        // Asynchronous reset in DONE clears a latched overflow.
        accept(504);
        wait_done();
        chk("pre_rst.ovf", bus.ovf, 1);
        rst = 1'b1;
        #1;
        chk("rst_done.out_valid", bus.out_valid, 0);
        check_res("rst_done", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full sweep of the dynamic range with random consumer stalls.
        for (int v = 0; v < 504; v++) begin
            accept(v);
            wait_done();
            repeat ($urandom_range(0, 3)) step();
            check_model($sformatf("sweep%0d", v), v);
            release_out();
        end

        // Random values across the whole input width, including overflow.
        for (int i = 0; i < 40; i++) begin
            int v;
            v = int'($urandom_range(0, 511));
            accept(v);
            wait_done();
            repeat ($urandom_range(0, 2)) step();
            check_model($sformatf("rand%0d", v), v);
            release_out();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_rns_9_8_7_seq.md
Name: bin_to_rns_9_8_7_seq

Overview:
- Sequential forward converter from binary to the residue number system with moduli (7, 8, 9), dynamic range 504.
- Produces residue triples in the same order and widths the RNS comparator consumes: x1 = mod 7, x2 = mod 8, x3 = mod 9.
- Sits upstream of the RNS arithmetic and compare blocks and feeds them from binary sources.
- Bit-serial MSB-first Horner reduction with a valid/ready handshake on both sides.

Parameters:
- IN_W, 9, binary input width; conversion latency is IN_W cycles; minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a new value
- in_data  input  IN_W  unsigned binary operand
- out_valid  output  1  residues are valid
- out_ready  input  1  consumer accepts the residues
- x1  output  3  in_data mod 7
- x2  output  3  in_data mod 8
- x3  output  4  in_data mod 9
- ovf  output  1  in_data >= 504, outside the dynamic range; residues are still produced

Behaviour:
- States and transitions:
  - IDLE -> BUSY on in_valid && in_ready.
  - BUSY -> DONE after IN_W bit steps.
  - DONE -> IDLE on out_valid && out_ready.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are registered-state decodes with no combinational path from inputs.
- Accept edge:
  - Load shift register with in_data.
  - Set bit counter to IN_W.
  - Clear internal residues r7, r8, r9 to 0.
  - Latch ovf = (in_data >= 504), compared at IN_W width; always 0 if IN_W < 9.
- Each BUSY edge:
  - Take b = shift register MSB, then shift left.
  - Update r_m <= (2*r_m + b) mod m for m = 7, 8, 9.
  - Decrement the counter. The edge that brings the counter to 0 enters DONE.
- Arithmetic:
  - 2*r + b fits in 5 bits (max 17).
  - Reduction is a single conditional subtract chain: subtract m at most twice. No divider.
  - The mod 8 path is a plain 3-bit shift-in.
- Latency: out_valid rises on the IN_W-th rising edge after the accept edge, i.e. IN_W + 1 edges counting the accept edge.
- Throughput: one conversion per IN_W + 2 cycles. No overlap.
- Outputs:
  - x1, x2, x3 and ovf are stable throughout DONE, for any number of cycles of out_ready low.
  - After the output handshake they hold their values until the next accept edge.
  - They may change during BUSY; consumers qualify them with out_valid.
- Input and output signals:
  - in_valid is ignored outside IDLE; in_data is not sampled after the accept edge.
  - out_ready is ignored outside DONE.
- Reset: asynchronous at any time, including mid-BUSY or in DONE. The conversion is discarded; state = IDLE, in_ready = 1, out_valid = 0, x1 = x2 = x3 = 0, ovf = 0, counter and shift register = 0. First accept is possible on the first edge after rst deasserts.
- Simultaneous events: an output handshake in DONE and a new in_valid on the same edge do not merge. The new value is accepted on a later edge in IDLE.

Decomposition:
- Package rns_9_8_7_pkg:
  - Moduli constants M1 = 7, M2 = 8, M3 = 9 and range constant 504.
  - Residue widths W1 = 3, W2 = 3, W3 = 4.
  - State enum IDLE/BUSY/DONE.
- Sub-module rns_mod_step, parameterised by modulus and width: combinational (2*r + b) mod m. Instantiated three times.

Test Plan:
- Convert 10 with out_ready = 1 -> (x1, x2, x3) = (3, 2, 1), ovf = 0; out_valid on the 9th edge after accept; in_ready low from accept until the return to IDLE.
- Convert 0 and 503 -> (0, 0, 0) and (6, 7, 8), ovf = 0.
- Convert 504 and 511 -> (0, 0, 0) with ovf = 1, and (0, 7, 7) with ovf = 1.
- Convert 100 (expect (2, 4, 1)) with out_ready low for 5 cycles in DONE -> outputs stable, in_ready = 0, new in_valid ignored; then one out_ready pulse -> IDLE.
- Pulse rst mid-BUSY during conversion of 255 -> immediate IDLE with outputs 0; then convert 255 -> (3, 7, 3).
- Chain to compare_9_8_7_const_10 and sweep 0..503 with random out_ready gaps -> gr/eq/le match (v > 10), (v == 10), (v < 10) for every value.
